// File: rtl/riscv_pkg.sv
// Shared pipeline types: stage register structs, their widths and NOP bubbles.
// rv_pipe_stage sizes WIDTH and BUBBLE from these constants.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        ctrl_t       ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_res;
        logic [31:0] st_data;
        ctrl_t       ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] wb_data;
        ctrl_t       ctrl;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    localparam ctrl_t CTRL_NOP = '{reg_we: 1'b0, mem_re: 1'b0,
                                   mem_we: 1'b0, alu_op: 4'd0};

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'd0, instr: NOP_INSTR};

    localparam id_ex_t ID_EX_BUBBLE = '{pc: 32'd0, instr: NOP_INSTR,
                                        rs1_val: 32'd0, rs2_val: 32'd0,
                                        imm: 32'd0, ctrl: CTRL_NOP};

    localparam ex_mem_t EX_MEM_BUBBLE = '{instr: NOP_INSTR,
                                          alu_res: 32'd0,
                                          st_data: 32'd0,
                                          ctrl: CTRL_NOP};

    localparam mem_wb_t MEM_WB_BUBBLE = '{instr: NOP_INSTR,
                                          wb_data: 32'd0,
                                          ctrl: CTRL_NOP};

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module rv_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/rv_pipe_stage.sv
// Elastic pipeline register: DEPTH-entry ring buffer, flush, back-pressure count.
// Define RV_PIPE_BYPASS_EN for a combinational in-to-out path when empty.
module rv_pipe_stage
    import riscv_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             bp_cnt,
    input  logic                         bp_clr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign in_ready = !w_full;
    assign count    = r_count;
    assign w_pop    = !w_empty && out_ready && !flush;

`ifdef RV_PIPE_BYPASS_EN
    logic w_byp;
    assign w_byp     = w_empty && !flush && in_valid;
    assign out_valid = !w_empty || w_byp;
    assign out_data  = !w_empty ? r_mem[r_rd_ptr] :
                       (w_byp ? in_data : BUBBLE);
    // A bypassed word taken downstream this cycle is never stored
    assign w_push    = in_valid && !w_full && !flush &&
                       !(w_empty && out_ready);
`else
    assign out_valid = !w_empty;
    assign out_data  = !w_empty ? r_mem[r_rd_ptr] : BUBBLE;
    assign w_push    = in_valid && !w_full && !flush;
`endif

    // Wrap explicitly so DEPTH need not be a power of two
    assign w_wr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    rv_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_valid && !in_ready),
        .clr   (bp_clr),
        .value (bp_cnt)
    );

endmodule
